// File: rtl/serial_addsub_unit_pkg.sv
// Shared ALU definitions for the serial adder/subtractor.
// FSM state encoding and the slice width.
package alu_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle for the serial adder/subtractor.
// master = producer/consumer side, slave = the unit.
interface serial_addsub_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op_sub, data_a, data_b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, op_sub, data_a, data_b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_addsub_unit_slice.sv
// Combinational 4-bit adder slice with carry-out and carry into bit 3.
// c3 feeds the signed overflow term on the final slice.
module addsub_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);
  logic [4:0] full;
  logic [3:0] low;

  assign full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  assign low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'd0, cin};
  assign sum  = full[3:0];
  assign cout = full[4];
  assign c3   = low[3];
endmodule

// File: rtl/serial_addsub_unit.sv
// Multi-cycle adder/subtractor: one 4-bit slice per clock, LSB first.
// One slice adder is reused each RUN cycle with a registered carry.
module serial_addsub_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_addsub_unit_if.slave  bus
);
  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

  if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_width_chk
    $error("serial_addsub_unit: WIDTH must be a multiple of 4");
  end

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [3:0]       sa;
  logic [3:0]       sb;
  logic [3:0]       ssum;
  logic             scout;
  logic             sc3;
  logic             last;

  assign last = (idx == LAST);
  assign sa   = op_a[SLICE_W*int'(idx) +: SLICE_W];
  assign sb   = op_b[SLICE_W*int'(idx) +: SLICE_W];

  addsub_slice4 u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .sum  (ssum),
    .cout (scout),
    .c3   (sc3)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: the +1 enters as the initial carry.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.data_a;
            op_b  <= bus.op_sub ? ~bus.data_b : bus.data_b;
            carry <= bus.op_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          res[SLICE_W*int'(idx) +: SLICE_W] <= ssum;
          carry <= scout;
          if (last) begin
            cout_q <= scout;
            ovf_q  <= sc3 ^ scout;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = res;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=32).
// Random and directed ops against an arithmetic reference model.
module tb_serial_addsub_unit;
  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  serial_addsub_unit_if #(.WIDTH(32)) bus ();

  serial_addsub_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {overflow, carry, result} from plain integer arithmetic
  function automatic logic [33:0] model(input logic sub,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     s;
    logic [31:0] r;
    logic       c;
    logic       v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r = a - b;
      c = (a >= b);
      s = sa - sb;
    end else begin
      r = a + b;
      c = ((64'(a) + 64'(b)) >= 64'h1_0000_0000);
      s = sa + sb;
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {v, c, r};
  endfunction

  task automatic run_op(input logic sub, input logic [31:0] a,
                        input logic [31:0] b, input string tag,
                        input int hold);
    logic [33:0] e;
    int          n;
    e = model(sub, a, b);
    check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.data_a   = a;
    bus.data_b   = b;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.data_a   = $urandom;
    bus.data_b   = $urandom;
    bus.op_sub   = ~sub;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'd8);
    check({tag, "/result"}, 64'(bus.result), 64'(e[31:0]));
    check({tag, "/carry"}, 64'(bus.carry_out), 64'(e[32]));
    check({tag, "/ovf"}, 64'(bus.overflow), 64'(e[33]));
    check({tag, "/busy"}, 64'(bus.busy), 64'd1);
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        check({tag, "/hold_res"}, 64'(bus.result), 64'(e[31:0]));
        check({tag, "/hold_flags"},
              64'({bus.out_valid, bus.in_ready, bus.carry_out, bus.overflow}),
              64'({1'b1, 1'b0, e[32], e[33]}));
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    check({tag, "/out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "/idle"}, 64'({bus.busy, bus.in_ready}), 64'b01);
    if (hold > 0)
      check({tag, "/not_taken"}, 64'(bus.result), 64'(e[31:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] q[$];
    int          acc[$];
    int          sent;
    int          got;
    logic        cs;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        took;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst/in_ready", 64'(bus.in_ready), 64'd0);
    check("rst/out", 64'({bus.out_valid, bus.busy, bus.carry_out, bus.overflow}),
          64'd0);
    check("rst/result", 64'(bus.result), 64'd0);
    reset = 1'b0;
    #1;

    run_op(1'b0, 32'h0000_0001, 32'h0000_0001, "add1", 0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf", 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "add_ripple", 0);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, "sub_ovf", 0);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0007, "sub_borrow", 0);
    run_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, "hold", 5);

    // abort mid-RUN at idx=3
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b0;
    bus.data_a   = 32'hFFFF_FFFF;
    bus.data_b   = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("abort/busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort/in_ready_rst", 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("abort/state", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    check("abort/result", 64'(bus.result), 64'd0);
    check("abort/flags", 64'({bus.carry_out, bus.overflow}), 64'd0);
    run_op(1'b1, 32'h0000_0000, 32'h0000_0001, "after_abort", 0);

    for (int i = 0; i < 12; i++)
      run_op(1'($urandom), $urandom, $urandom, "rand", 0);

    // back-to-back with handshakes held high
    sent = 0;
    got  = 0;
    cs   = 1'($urandom);
    ca   = $urandom;
    cb   = $urandom;
    bus.op_sub    = cs;
    bus.data_a    = ca;
    bus.data_b    = cb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 8; c++) begin
      @(negedge clock);
      took = 1'b0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("b2b/unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          check("b2b/result", 64'(bus.result), 64'(q[0][31:0]));
          check("b2b/flags", 64'({bus.carry_out, bus.overflow}),
                64'({q[0][32], q[0][33]}));
          void'(q.pop_front());
        end
        got++;
      end
      if (bus.in_ready && bus.in_valid) begin
        q.push_back(model(cs, ca, cb));
        acc.push_back(c);
        sent++;
        took = 1'b1;
      end
      @(posedge clock); #1;
      if (took) begin
        cs = 1'($urandom);
        ca = $urandom;
        cb = $urandom;
        bus.op_sub   = cs;
        bus.data_a   = ca;
        bus.data_b   = cb;
        bus.in_valid = (sent < 8);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b/count", 64'(got), 64'd8);
    for (int i = 1; i < acc.size(); i++)
      check("b2b/spacing", 64'(acc[i] - acc[i-1]), 64'd10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
